// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - M-stage load/store front end: alignment check, bus req/ack handshake, W-stage capture
module mem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m_valid,
  input  logic        m_rd,
  input  logic        m_wr,
  input  logic [1:0]  m_size,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [2:0]  m_dmext_op,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic [31:0] w_din,
  output logic [1:0]  w_addr_byte,
  output logic [2:0]  w_dmext_op,
  output logic        w_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       addr_byte_q;
  logic [2:0]       op_q;
  logic             dbe;
  logic             mem_op, misalign, start, expire;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;

  // During the bus-error cycle the aborted instruction is still in M; keep it from re-issuing.
  assign mem_op = m_valid & (m_rd | m_wr) & ~flush & ~dbe;
  assign start  = (state == IDLE) & mem_op & ~misalign;
  assign expire = (cnt == CNT_W'(TIMEOUT - 1)) & ~bus_ack;

  always_comb begin
    misalign = 1'b0;
    be_c     = 4'b0000;
    wdata_c  = m_wdata;
    case (m_size)
      2'b00: begin
        be_c    = 4'b0001 << m_addr[1:0];
        wdata_c = {4{m_wdata[7:0]}};
      end
      2'b01: begin
        misalign = m_addr[0];
        be_c     = m_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{m_wdata[15:0]}};
      end
      2'b10: begin
        misalign = |m_addr[1:0];
        be_c     = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = BUSY;
      BUSY: if (bus_ack || expire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    exc      = 1'b0;
    exc_code = 5'd0;
    case (state)
      IDLE: begin
        stall = start;
        if (dbe) begin
          exc      = 1'b1;
          exc_code = 5'd7;
        end else if (mem_op && misalign) begin
          exc      = 1'b1;
          exc_code = m_rd ? 5'd4 : 5'd5;
        end
      end
      BUSY: stall = ~bus_ack;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      cnt         <= '0;
      addr_byte_q <= '0;
      op_q        <= '0;
      dbe         <= 1'b0;
      w_din       <= '0;
      w_addr_byte <= '0;
      w_dmext_op  <= '0;
      w_valid     <= 1'b0;
    end else begin
      w_valid <= 1'b0;
      dbe     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          bus_req     <= 1'b1;
          bus_we      <= m_wr;
          bus_addr    <= {m_addr[31:2], 2'b00};
          bus_be      <= be_c;
          bus_wdata   <= wdata_c;
          cnt         <= '0;
          addr_byte_q <= m_addr[1:0];
          op_q        <= m_dmext_op;
        end
        BUSY: begin
          if (bus_ack) begin
            bus_req     <= 1'b0;
            w_din       <= bus_we ? 32'd0 : bus_rdata;
            w_addr_byte <= addr_byte_q;
            w_dmext_op  <= op_q;
            w_valid     <= 1'b1;
          end else if (expire) begin
            bus_req <= 1'b0;
            dbe     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
